// File: rtl/gfx_burst_arbiter.sv
// gfx_burst_arbiter: round-robin owner of the SDRAM write-burst port, holding each grant until the owner pulses done.
module gfx_burst_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int BURST_BITS = 10,
   parameter int ADDR_BITS  = 22,
   parameter int IDX_BITS   = 2
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [NUM_REQ-1:0]              req_burst_req,
   input  logic [NUM_REQ*BURST_BITS-1:0]   req_burst_len,
   input  logic [NUM_REQ*ADDR_BITS-1:0]    req_addr,
   input  logic [NUM_REQ*16-1:0]           req_rgb,
   input  logic [NUM_REQ-1:0]              req_done,
   output logic [NUM_REQ-1:0]              req_data_req,
   output logic [NUM_REQ-1:0]              req_data_finish,
   output logic                            write_burst_req,
   output logic [BURST_BITS-1:0]           write_burst_len,
   output logic [ADDR_BITS-1:0]            addr,
   output logic [15:0]                     rgb,
   input  logic                            write_burst_data_req,
   input  logic                            write_burst_data_finish,
   output logic [NUM_REQ-1:0]              grant,
   output logic [IDX_BITS-1:0]             grant_id,
   output logic                            busy
);
   typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;
   state_t                state;
   logic [IDX_BITS-1:0]   last_ptr, next_id, cand;
   logic                  found, burst_active, seen_data, in_grant;
   logic [BURST_BITS-1:0] len_a  [NUM_REQ];
   logic [ADDR_BITS-1:0]  addr_a [NUM_REQ];
   logic [15:0]           rgb_a  [NUM_REQ];

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
      assign len_a[i]  = req_burst_len[i*BURST_BITS +: BURST_BITS];
      assign addr_a[i] = req_addr[i*ADDR_BITS +: ADDR_BITS];
      assign rgb_a[i]  = req_rgb[i*16 +: 16];
   end

   // scan starts just after the previous owner and wraps at NUM_REQ
   always_comb begin
      next_id = '0;
      found   = 1'b0;
      cand    = last_ptr;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = (cand == IDX_BITS'(NUM_REQ-1)) ? '0 : cand + 1'b1;
         if (!found && req_burst_req[cand]) begin
            next_id = cand;
            found   = 1'b1;
         end
      end
   end

   assign in_grant        = (state == GRANT);
   assign write_burst_req = in_grant && req_burst_req[grant_id];
   assign write_burst_len = len_a[grant_id];
   assign addr            = addr_a[grant_id];
   assign rgb             = rgb_a[grant_id];
   assign req_data_req    = (in_grant && write_burst_data_req) ? grant : '0;
   assign req_data_finish = (in_grant && write_burst_data_finish) ? grant : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         grant        <= '0;
         grant_id     <= '0;
         busy         <= 1'b0;
         last_ptr     <= IDX_BITS'(NUM_REQ-1);
         burst_active <= 1'b0;
         seen_data    <= 1'b0;
      end else begin
         unique case (state)
            IDLE: if (found) begin
               grant    <= NUM_REQ'(1) << next_id;
               grant_id <= next_id;
               busy     <= 1'b1;
               state    <= GRANT;
            end
            GRANT: begin
               if (write_burst_data_req) seen_data <= 1'b1;
               burst_active <= !write_burst_data_finish && (burst_active || write_burst_data_req);
               // a request drop only counts as abandon before the first data beat
               if (req_done[grant_id] || (!req_burst_req[grant_id] && !seen_data)) begin
                  state    <= RELEASE;
                  grant    <= '0;
                  last_ptr <= grant_id;
               end
            end
            RELEASE: begin
               burst_active <= 1'b0;
               seen_data    <= 1'b0;
               busy         <= 1'b0;
               state        <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_gfx_burst_arbiter.sv
// tb_gfx_burst_arbiter: directed stimulus with a grant scoreboard checked by a negedge monitor.
module tb_gfx_burst_arbiter;
   localparam int N = 4, BB = 10, AB = 22, IB = 2;
   localparam logic [AB-1:0] E_ADDR [N] = '{22'h000100, 22'h002000, 22'h3FFFFF, 22'h155555};
   localparam logic [BB-1:0] E_LEN  [N] = '{10'd128, 10'd64, 10'd1023, 10'd1};
   localparam logic [15:0]   E_RGB  [N] = '{16'hF800, 16'h07E0, 16'h001F, 16'hFFFF};

   logic            clk = 1'b0, rst_n = 1'b0;
   logic [N-1:0]    req_burst_req = '0, req_done = '0;
   logic [N*BB-1:0] req_burst_len = {10'd1, 10'd1023, 10'd64, 10'd128};
   logic [N*AB-1:0] req_addr = {22'h155555, 22'h3FFFFF, 22'h002000, 22'h000100};
   logic [N*16-1:0] req_rgb = {16'hFFFF, 16'h001F, 16'h07E0, 16'hF800};
   logic [N-1:0]    req_data_req, req_data_finish, grant;
   logic            write_burst_req, busy;
   logic [BB-1:0]   write_burst_len;
   logic [AB-1:0]   addr;
   logic [15:0]     rgb;
   logic            write_burst_data_req = 1'b0, write_burst_data_finish = 1'b0;
   logic [IB-1:0]   grant_id;

   int n_chk = 0, n_pass = 0;
   int q[$];
   int dcnt [N];
   int fcnt [N];
   int base [N];
   logic [N-1:0] prev_grant = '0;

   always #5 clk = ~clk;

   gfx_burst_arbiter #(.NUM_REQ(N), .BURST_BITS(BB), .ADDR_BITS(AB), .IDX_BITS(IB)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_burst_req(req_burst_req), .req_burst_len(req_burst_len), .req_addr(req_addr),
      .req_rgb(req_rgb), .req_done(req_done),
      .req_data_req(req_data_req), .req_data_finish(req_data_finish),
      .write_burst_req(write_burst_req), .write_burst_len(write_burst_len),
      .addr(addr), .rgb(rgb),
      .write_burst_data_req(write_burst_data_req), .write_burst_data_finish(write_burst_data_finish),
      .grant(grant), .grant_id(grant_id), .busy(busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   always @(negedge clk) begin
      for (int i = 0; i < N; i++) begin
         dcnt[i] <= dcnt[i] + int'(req_data_req[i]);
         fcnt[i] <= fcnt[i] + int'(req_data_finish[i]);
      end
      if (grant != '0 && prev_grant == '0) begin
         if (q.size() == 0) chk("unexpected_grant", 32'(grant), 32'h0);
         else begin
            chk("grant", 32'(grant), 32'(1) << q[0]);
            chk("grant_id", 32'(grant_id), 32'(q[0]));
            chk("write_burst_req", 32'(write_burst_req), 32'h1);
            chk("addr", 32'(addr), 32'(E_ADDR[q[0]]));
            chk("len", 32'(write_burst_len), 32'(E_LEN[q[0]]));
            chk("rgb", 32'(rgb), 32'(E_RGB[q[0]]));
            void'(q.pop_front());
         end
      end
      prev_grant <= grant;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_grant(input int id);
      int t = 0;
      while (grant !== N'(1) << id && t < 40) begin
         tick();
         t++;
      end
      if (t >= 40) chk("grant_timeout", 32'(grant), 32'(1) << id);
   endtask

   task automatic bursts(input int nb, input int beats);
      for (int b = 0; b < nb; b++) begin
         for (int k = 0; k < beats; k++) begin
            write_burst_data_req = 1'b1;
            tick();
         end
         write_burst_data_req    = 1'b0;
         write_burst_data_finish = 1'b1;
         tick();
         write_burst_data_finish = 1'b0;
      end
   endtask

   task automatic serve(input int id, input int nb, input int beats, input bit keep);
      wait_grant(id);
      bursts(nb, beats);
      req_done[id] = 1'b1;
      if (!keep) req_burst_req[id] = 1'b0;
      tick();
      req_done[id] = 1'b0;
   endtask

   task automatic reset_dut();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      tick();
      tick();
      chk("rst_grant", 32'(grant), 32'h0);
      chk("rst_grant_id", 32'(grant_id), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_wbreq", 32'(write_burst_req), 32'h0);
      chk("rst_data_req", 32'(req_data_req), 32'h0);
      rst_n = 1'b1;
      tick();
      // single requester, 128-beat burst
      base = dcnt;
      req_burst_req = 4'b0001;
      q.push_back(0);
      wait_grant(0);
      bursts(1, 128);
      tick();
      chk("beats_eng0", 32'(dcnt[0] - base[0]), 32'd128);
      chk("beats_others", 32'(dcnt[1] + dcnt[2] + dcnt[3] - base[1] - base[2] - base[3]), 32'd0);
      chk("finish_eng0", 32'(fcnt[0]), 32'd1);
      req_done[0] = 1'b1;
      req_burst_req[0] = 1'b0;
      tick();
      req_done[0] = 1'b0;
      chk("release_busy", 32'(busy), 32'h1);
      chk("release_grant", 32'(grant), 32'h0);
      chk("release_wbreq", 32'(write_burst_req), 32'h0);
      tick();
      chk("idle_busy", 32'(busy), 32'h0);
      // round-robin from reset: 0,1,2,3,0
      reset_dut();
      req_burst_req = 4'b1111;
      q.push_back(0); q.push_back(1); q.push_back(2); q.push_back(3); q.push_back(0);
      serve(0, 3, 4, 1);
      serve(1, 3, 4, 1);
      serve(2, 3, 4, 1);
      serve(3, 3, 4, 1);
      req_burst_req = 4'b0001;
      serve(0, 3, 4, 0);
      // hold across request drop
      req_burst_req[1] = 1'b1;
      q.push_back(1);
      wait_grant(1);
      write_burst_data_req = 1'b1;
      tick();
      write_burst_data_req = 1'b0;
      req_burst_req[1] = 1'b0;
      req_burst_req[2] = 1'b1;
      q.push_back(2);
      repeat (3) tick();
      chk("hold_grant", 32'(grant), 32'h2);
      chk("hold_busy", 32'(busy), 32'h1);
      write_burst_data_finish = 1'b1;
      tick();
      write_burst_data_finish = 1'b0;
      chk("hold_grant2", 32'(grant), 32'h2);
      req_done[1] = 1'b1;
      tick();
      req_done[1] = 1'b0;
      serve(2, 1, 2, 0);
      // abandon by engine 3, then engine 0 next; spurious non-owner done
      req_burst_req[3] = 1'b1;
      q.push_back(3);
      wait_grant(3);
      tick();
      req_burst_req[3] = 1'b0;
      req_burst_req[0] = 1'b1;
      q.push_back(0);
      tick();
      chk("abandon_grant", 32'(grant), 32'h0);
      chk("abandon_busy", 32'(busy), 32'h1);
      wait_grant(0);
      req_done[2] = 1'b1;
      tick();
      req_done[2] = 1'b0;
      chk("nonowner_done", 32'(grant), 32'h1);
      tick();
      chk("nonowner_done2", 32'(grant), 32'h1);
      serve(0, 1, 2, 0);
      // downstream pulses while idle are dropped
      tick();
      tick();
      write_burst_data_req = 1'b1;
      tick();
      chk("idle_data_req", 32'(req_data_req), 32'h0);
      chk("idle_wbreq", 32'(write_burst_req), 32'h0);
      write_burst_data_req = 1'b0;
      write_burst_data_finish = 1'b1;
      tick();
      chk("idle_finish", 32'(req_data_finish), 32'h0);
      write_burst_data_finish = 1'b0;
      // owner done together with new requests: old owner not regranted first
      req_burst_req[1] = 1'b1;
      q.push_back(1);
      wait_grant(1);
      bursts(1, 2);
      req_done[1] = 1'b1;
      req_burst_req[2] = 1'b1;
      q.push_back(2);
      tick();
      req_done[1] = 1'b0;
      q.push_back(1);
      serve(2, 1, 2, 0);
      serve(1, 1, 2, 0);
      // reset during the 50th data beat
      req_burst_req[2] = 1'b1;
      q.push_back(2);
      wait_grant(2);
      repeat (49) begin
         write_burst_data_req = 1'b1;
         tick();
      end
      #1 rst_n = 1'b0;
      #1;
      chk("midrst_grant", 32'(grant), 32'h0);
      chk("midrst_wbreq", 32'(write_burst_req), 32'h0);
      chk("midrst_data_req", 32'(req_data_req), 32'h0);
      chk("midrst_busy", 32'(busy), 32'h0);
      write_burst_data_req = 1'b0;
      req_burst_req[0] = 1'b1;
      tick();
      tick();
      q.push_back(0);
      q.push_back(2);
      rst_n = 1'b1;
      serve(0, 1, 2, 0);
      serve(2, 1, 2, 0);
      repeat (5) tick();
      chk("queue_empty", 32'(q.size()), 32'h0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
